// File: rtl/elevator_request_scheduler.sv
// LOOK-policy floor-call scheduler in front of the elevator controller.
// Latches calls, dispatches one target at a time and times the door dwell.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS  = 4,
  parameter int DOOR_CYCLES = 8,
  parameter int TIMER_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] CALL_REQ,
  input  logic [3:0]            CAR_FLOOR,
  input  logic                  CAR_COMPLETE,
  input  logic                  DOOR_ALERT,
  input  logic                  WEIGHT_ALERT,
  output logic [3:0]            TARGET_FLOOR,
  output logic                  TARGET_VALID,
  output logic                  SERVICE_DIR,
  output logic                  DOOR_OPEN,
  output logic                  SERVED,
  output logic [NUM_FLOORS-1:0] PENDING
);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    MOVE,
    DOOR
  } state_t;

  localparam logic [3:0] TOP = 4'(NUM_FLOORS - 1);
  localparam logic [TIMER_W-1:0] DWELL = TIMER_W'(DOOR_CYCLES - 1);

  state_t               state, state_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [NUM_FLOORS-1:0] pend_n, req, clr;
  logic [3:0]           car, tgt_n;
  logic [3:0]           up_lo, dn_hi, up_near, dn_near;
  logic                 has_up, has_dn, has_up_near, has_dn_near;
  logic                 here, alert, arrive;
  logic                 valid_n, dir_n, door_n, served_n;

  assign car   = (CAR_FLOOR > TOP) ? TOP : CAR_FLOOR;
  assign alert = DOOR_ALERT | WEIGHT_ALERT;

  // Nearest pending floors above/below the car, and between car and target
  always_comb begin
    has_up      = 1'b0;
    has_dn      = 1'b0;
    has_up_near = 1'b0;
    has_dn_near = 1'b0;
    here        = 1'b0;
    up_lo       = '0;
    dn_hi       = '0;
    up_near     = '0;
    dn_near     = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (PENDING[i] && 4'(i) > car) begin
        has_up = 1'b1;
        up_lo  = 4'(i);
        if (4'(i) < TARGET_FLOOR) begin
          has_up_near = 1'b1;
          up_near     = 4'(i);
        end
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (PENDING[i] && 4'(i) < car) begin
        has_dn = 1'b1;
        dn_hi  = 4'(i);
        if (4'(i) > TARGET_FLOOR) begin
          has_dn_near = 1'b1;
          dn_near     = 4'(i);
        end
      end
      if (PENDING[i] && 4'(i) == car)
        here = 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    tgt_n    = TARGET_FLOOR;
    valid_n  = TARGET_VALID;
    dir_n    = SERVICE_DIR;
    door_n   = DOOR_OPEN;
    served_n = 1'b0;
    timer_n  = timer;
    arrive   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|PENDING)
          state_n = SELECT;
      end
      SELECT: begin
        if (PENDING == '0) begin
          state_n = IDLE;
        end else begin
          state_n = MOVE;
          valid_n = 1'b1;
          if (here) begin
            tgt_n = car;
          end else if (SERVICE_DIR) begin
            if (has_up) begin
              tgt_n = up_lo;
            end else begin
              dir_n = 1'b0;
              tgt_n = dn_hi;
            end
          end else if (has_dn) begin
            tgt_n = dn_hi;
          end else begin
            dir_n = 1'b1;
            tgt_n = up_lo;
          end
        end
      end
      MOVE: begin
        if (CAR_COMPLETE && car == TARGET_FLOOR) begin
          arrive   = 1'b1;
          served_n = 1'b1;
          valid_n  = 1'b0;
          door_n   = 1'b1;
          timer_n  = DWELL;
          state_n  = DOOR;
        end else if (!alert) begin
          if (SERVICE_DIR && has_up_near)
            tgt_n = up_near;
          else if (!SERVICE_DIR && has_dn_near)
            tgt_n = dn_near;
        end
      end
      DOOR: begin
        if (alert) begin
          timer_n = DWELL;
        end else if (timer == '0) begin
          door_n  = 1'b0;
          state_n = (|PENDING) ? SELECT : IDLE;
        end else begin
          timer_n = timer - TIMER_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Calls at the open-door floor are swallowed; the served bit is cleared
  always_comb begin
    for (int i = 0; i < NUM_FLOORS; i++) begin
      req[i] = CALL_REQ[i] &&
               !(state == DOOR && 4'(i) == TARGET_FLOOR);
      clr[i] = arrive && 4'(i) == TARGET_FLOOR;
    end
    pend_n = (PENDING | req) & ~clr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      PENDING      <= '0;
      TARGET_FLOOR <= '0;
      TARGET_VALID <= 1'b0;
      SERVICE_DIR  <= 1'b0;
      DOOR_OPEN    <= 1'b0;
      SERVED       <= 1'b0;
      timer        <= '0;
    end else begin
      state        <= state_n;
      PENDING      <= pend_n;
      TARGET_FLOOR <= tgt_n;
      TARGET_VALID <= valid_n;
      SERVICE_DIR  <= dir_n;
      DOOR_OPEN    <= door_n;
      SERVED       <= served_n;
      timer        <= timer_n;
    end
  end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler.
// Served floors are checked against a queue of expected floors.
module tb_elevator_request_scheduler;

  localparam int NF = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NF-1:0] call_req = '0;
  logic [3:0]    car_floor = '0;
  logic          car_complete = 1'b0;
  logic          door_alert = 1'b0;
  logic          weight_alert = 1'b0;
  logic [3:0]    target_floor;
  logic          target_valid;
  logic          service_dir;
  logic          door_open;
  logic          served;
  logic [NF-1:0] pending;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  elevator_request_scheduler #(
    .NUM_FLOORS(NF),
    .DOOR_CYCLES(8),
    .TIMER_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .CALL_REQ(call_req),
    .CAR_FLOOR(car_floor),
    .CAR_COMPLETE(car_complete),
    .DOOR_ALERT(door_alert),
    .WEIGHT_ALERT(weight_alert),
    .TARGET_FLOOR(target_floor),
    .TARGET_VALID(target_valid),
    .SERVICE_DIR(service_dir),
    .DOOR_OPEN(door_open),
    .SERVED(served),
    .PENDING(pending)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [NF-1:0] v);
    call_req = v;
    tick();
    call_req = '0;
  endtask

  task automatic arrive(input logic [3:0] f, input int t);
    car_floor    = f;
    car_complete = 1'b1;
    exp_q.push_back(t);
    tick();
    car_complete = 1'b0;
    check("served_pulse", 32'(served), 1);
    check("door_open", 32'(door_open), 1);
    check("valid_off", 32'(target_valid), 0);
  endtask

  task automatic dwell(input string tag, input int want);
    int n = 0;
    while (door_open === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check(tag, n, want);
  endtask

  always @(negedge clk) begin
    if (rst && served) begin
      check("sb_has_entry", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0)
        check("served_floor", 32'(target_floor), exp_q.pop_front());
    end
  end

  initial begin
    tick(2);
    check("rst_tgt", 32'(target_floor), 0);
    check("rst_valid", 32'(target_valid), 0);
    check("rst_dir", 32'(service_dir), 0);
    check("rst_door", 32'(door_open), 0);
    check("rst_served", 32'(served), 0);
    check("rst_pend", 32'(pending), 0);
    rst = 1'b1;
    tick();

    // single call to the top floor
    pulse(4'b1000);
    check("s1_pend", 32'(pending), 32'b1000);
    check("s1_valid_early", 32'(target_valid), 0);
    tick(2);
    check("s1_tgt", 32'(target_floor), 3);
    check("s1_valid", 32'(target_valid), 1);
    check("s1_dir", 32'(service_dir), 1);
    arrive(4'd3, 3);
    check("s1_pend_clr", 32'(pending), 0);
    check("s1_tgt_hold", 32'(target_floor), 3);
    dwell("s1_dwell", 8);
    tick(3);
    check("s1_idle", 32'(target_valid), 0);

    // intermediate call retargets the dispatch
    car_floor = 4'd0;
    pulse(4'b1000);
    tick(2);
    check("s2_tgt3", 32'(target_floor), 3);
    pulse(4'b0010);
    check("s2_tgt_still3", 32'(target_floor), 3);
    tick();
    check("s2_retgt", 32'(target_floor), 1);
    check("s2_pend", 32'(pending), 32'b1010);
    arrive(4'd1, 1);
    check("s2_pend_keep3", 32'(pending), 32'b1000);
    dwell("s2_dwell1", 8);
    tick();
    check("s2_tgt_resel", 32'(target_floor), 3);
    check("s2_valid", 32'(target_valid), 1);
    arrive(4'd3, 3);
    pulse(4'b1000);
    check("s2_door_drop", 32'(pending), 0);
    dwell("s2_dwell3", 7);

    // direction reversal, then door alert extends dwell
    car_floor = 4'd2;
    pulse(4'b0001);
    tick(2);
    check("s3_tgt", 32'(target_floor), 0);
    check("s3_dir", 32'(service_dir), 0);
    arrive(4'd0, 0);
    tick(2);
    door_alert = 1'b1;
    tick(5);
    door_alert = 1'b0;
    check("s3_alert_hold", 32'(door_open), 1);
    dwell("s3_dwell_alert", 8);

    // weight alert freezes retargeting, then extends dwell
    pulse(4'b1000);
    tick(2);
    check("s4_tgt3", 32'(target_floor), 3);
    check("s4_dir", 32'(service_dir), 1);
    weight_alert = 1'b1;
    pulse(4'b0100);
    check("s4_frozen1", 32'(target_floor), 3);
    tick(3);
    check("s4_frozen2", 32'(target_floor), 3);
    check("s4_pend", 32'(pending), 32'b1100);
    weight_alert = 1'b0;
    tick();
    check("s4_retgt", 32'(target_floor), 2);
    arrive(4'd2, 2);
    tick();
    weight_alert = 1'b1;
    tick(5);
    weight_alert = 1'b0;
    dwell("s4_dwell_weight", 8);
    tick();
    check("s4_tgt_resel", 32'(target_floor), 3);
    arrive(4'd3, 3);
    dwell("s4_dwell3", 8);

    // asynchronous reset mid-MOVE
    pulse(4'b0110);
    tick(2);
    check("s5_tgt", 32'(target_floor), 2);
    check("s5_dir", 32'(service_dir), 0);
    check("s5_pend", 32'(pending), 32'b0110);
    #2 rst = 1'b0;
    #1;
    check("s5_ar_pend", 32'(pending), 0);
    check("s5_ar_tgt", 32'(target_floor), 0);
    check("s5_ar_valid", 32'(target_valid), 0);
    check("s5_ar_dir", 32'(service_dir), 0);
    check("s5_ar_door", 32'(door_open), 0);
    tick();
    rst = 1'b1;
    tick(3);
    check("s5_post_valid", 32'(target_valid), 0);
    check("s5_post_pend", 32'(pending), 0);

    // out-of-range car floor is clamped to the top floor
    car_floor = 4'hF;
    pulse(4'b1000);
    tick(2);
    check("s6_tgt", 32'(target_floor), 3);
    check("s6_valid", 32'(target_valid), 1);
    arrive(4'hF, 3);
    check("s6_pend", 32'(pending), 0);
    tick(2);
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
